// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite types and helpers for the parametrised memory slave.
// Byte-enable generation lives here so the slave and any neighbours agree on lane order.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    DP_NONE,
    DP_WAIT,
    DP_LAST,
    DP_ERR1,
    DP_ERR2
  } dp_state_e;

  // Little-endian lane mask for a transfer of 2**hsize bytes starting at addr_lsb,
  // clipped to the nbytes lanes that exist on the bus.
  function automatic logic [7:0] be_from_size(input logic [2:0] addr_lsb,
                                              input logic [2:0] hsize,
                                              input int nbytes);
    logic [7:0] be;
    int first;
    int last;
    first = int'(addr_lsb);
    last  = first + (1 << hsize);
    for (int i = 0; i < 8; i++) begin
      be[i] = (i < nbytes) && (i >= first) && (i < last);
    end
    return be;
  endfunction

endpackage

// File: rtl/ahb_lite_mem_array.sv
// Word-organised storage with per-byte write enables: synchronous write, asynchronous read.
// One narrow array per byte lane so partial writes never need a read-modify-write.
module ahb_lite_mem_array #(
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  localparam int NBYTES   = DATA_W / 8,
  localparam int IDX_W    = $clog2(MEM_DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [NBYTES-1:0] be,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [7:0] lane_mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
      if (we && be[gi]) begin
        lane_mem[addr] <= wdata[gi*8 +: 8];
      end
    end

    assign rdata[gi*8 +: 8] = lane_mem[addr];
  end

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// Parametrised AHB-Lite scratch-RAM slave: programmable wait states, byte-lane writes,
// a write-protected upper region and two-cycle ERROR responses.
module ahb_lite_mem_slave
  import ahb_lite_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              MEM_DEPTH   = 256,
  parameter int              WAIT_STATES = 0,
  parameter longint unsigned RO_BASE     = MEM_DEPTH * DATA_W / 8
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [3:0]        hprot,
  input  logic [1:0]        htrans,
  input  logic              hready_i,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hresp,
  output logic              hreadyout
);

  localparam int NBYTES = DATA_W / 8;
  localparam int LSB_W  = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int AREG_W = LSB_W + IDX_W;
  localparam logic [ADDR_W:0] RO_LIM = (ADDR_W+1)'(RO_BASE);

  dp_state_e         state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic [AREG_W-1:0] addr_reg;
  logic              write_reg;
  logic [2:0]        size_reg;

  logic              accept;
  logic              take;
  logic              err_now;
  logic [ADDR_W-1:0] align_mask;
  logic              mem_we;
  logic [NBYTES-1:0] mem_be;
  logic [DATA_W-1:0] mem_rdata;
  logic              unused_ok;

  assign unused_ok = ^{hburst, hprot};

  assign accept = hsel && hready_i &&
                  ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  // Only states that drive hreadyout high can open a new data phase.
  assign take   = accept && hreadyout;

  assign align_mask = (ADDR_W'(1) << hsize) - ADDR_W'(1);
  assign err_now = (hsize > 3'(LSB_W)) ||
                   ((haddr & align_mask) != '0) ||
                   ((haddr >> LSB_W) >= ADDR_W'(MEM_DEPTH)) ||
                   (hwrite && ({1'b0, haddr} >= RO_LIM));

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_reg <= DP_NONE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      addr_reg  <= '0;
      write_reg <= 1'b0;
      size_reg  <= '0;
    end else if (take) begin
      addr_reg  <= haddr[AREG_W-1:0];
      write_reg <= hwrite;
      size_reg  <= hsize;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      DP_NONE, DP_LAST, DP_ERR2: begin
        if (!accept) begin
          state_next = DP_NONE;
        end else if (err_now) begin
          state_next = DP_ERR1;
        end else if (WAIT_STATES == 0) begin
          state_next = DP_LAST;
        end else begin
          state_next = DP_WAIT;
          cnt_next   = 4'(WAIT_STATES - 1);
        end
      end
      DP_WAIT: begin
        if (cnt_reg == '0) begin
          state_next = DP_LAST;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DP_ERR1: state_next = DP_ERR2;
      default: state_next = DP_NONE;
    endcase
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state_reg)
      DP_WAIT: hreadyout = 1'b0;
      DP_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
      end
      DP_ERR2: hresp = HRESP_ERROR;
      default: ;
    endcase
  end

  // Write commits on the edge that closes DP_LAST, so a following read sees it.
  assign mem_we = (state_reg == DP_LAST) && write_reg;
  assign mem_be = NBYTES'(be_from_size(3'(addr_reg[LSB_W-1:0]), size_reg, NBYTES));
  assign hrdata = ((state_reg == DP_LAST) && !write_reg) ? mem_rdata : '0;

  ahb_lite_mem_array #(
    .DATA_W   (DATA_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_mem (
    .clk  (hclk),
    .we   (mem_we),
    .be   (mem_be),
    .addr (addr_reg[AREG_W-1:LSB_W]),
    .wdata(hwdata),
    .rdata(mem_rdata)
  );

endmodule
